// File: rtl/window_seq_pkg.sv
// Shared types and helpers for the sliding-window sequencer.
// State encoding plus counter width helpers used by ports and counters.
package window_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM,
        ST_DONE
    } state_e;

    // Column counter width; never narrower than one bit.
    function automatic int col_w(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

    // Row counter width; never narrower than one bit.
    function automatic int row_w(input int height);
        return (height <= 1) ? 1 : $clog2(height);
    endfunction

endpackage

// File: rtl/window_seq_ctrl_counter_roll.sv
// Rolling up-counter: counts 0..max_val_p and wraps back to 0.
// restart_i makes the step start from zero instead of the held value.
module counter_roll #(
    parameter int max_val_p = 1,
    parameter int width_p   = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               restart_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    localparam logic [width_p-1:0] MAX = width_p'(max_val_p);

    logic [width_p-1:0] r_count;
    logic [width_p-1:0] w_base;

    // Value the next step starts from.
    always_comb begin
        w_base = restart_i ? '0 : r_count;
    end

    // Count register; only moves on an up strobe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (up_i) begin
            r_count <= (w_base == MAX) ? '0 : w_base + 1'b1;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/window_seq_ctrl.sv
// Sliding-window sequencer: tracks pixel position, gates window beats.
// Optional stats outputs under macro WINDOW_SEQ_CTRL_STATS_EN.
module window_seq_ctrl
    import window_seq_pkg::*;
#(
    parameter int width_p  = 640,
    parameter int height_p = 480,
    parameter int kernel_p = 3
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          valid_i,
    input  logic                          sof_i,
    output logic                          ready_o,
    output logic                          shift_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [col_w(width_p)-1:0]     col_o,
    output logic [row_w(height_p)-1:0]    row_o,
`ifdef WINDOW_SEQ_CTRL_STATS_EN
    output logic [15:0]                   frame_count_o,
    output logic [0:0]                    err_o,
`endif
    output logic                          frame_done_o
);

    localparam int CW = col_w(width_p);
    localparam int RW = row_w(height_p);

    localparam logic [CW-1:0] COL_MAX = CW'(width_p - 1);
    localparam logic [CW-1:0] COL_K   = CW'(kernel_p - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(height_p - 1);
    localparam logic [RW-1:0] ROW_K   = RW'(kernel_p - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [RW-1:0]   r_row;
    logic [RW-1:0]   w_row_eff;
    logic [RW-1:0]   w_row_nxt;
    logic [CW-1:0]   w_col_cnt;
    logic [CW-1:0]   w_col_eff;
    logic            w_active;
    logic            w_sync;
    logic            w_in_win;
    logic            w_ready;
    logic            w_shift;
    logic            w_col_wrap;
    logic            w_last;

    // Effective position, handshake and next row; a mid-frame sof
    // relabels the offered pixel as (0,0).
    always_comb begin
        w_active   = (r_state == ST_PRIME) || (r_state == ST_STREAM);
        w_sync     = valid_i && sof_i && w_active
                     && ((r_row != '0) || (w_col_cnt != '0));
        w_col_eff  = w_sync ? '0 : w_col_cnt;
        w_row_eff  = w_sync ? '0 : r_row;
        w_in_win   = (w_row_eff >= ROW_K) && (w_col_eff >= COL_K);
        w_ready    = (r_state == ST_DONE) ? 1'b0
                   : (w_in_win ? ready_i : 1'b1);
        w_shift    = valid_i && w_ready;
        w_col_wrap = (w_col_eff == COL_MAX);
        w_last     = w_col_wrap && (w_row_eff == ROW_MAX);
        w_row_nxt  = w_row_eff;
        if (w_col_wrap) begin
            w_row_nxt = (w_row_eff == ROW_MAX) ? '0 : w_row_eff + 1'b1;
        end
    end

    counter_roll #(
        .max_val_p (width_p - 1),
        .width_p   (CW)
    ) u_col (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .restart_i (w_sync),
        .up_i      (w_shift),
        .count_o   (w_col_cnt)
    );

    // Row register advances on column wrap of an accepted pixel.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_row <= '0;
        end else if (w_shift) begin
            r_row <= w_row_nxt;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE is a single-cycle pass back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_shift) begin
                    w_state_nxt = w_last ? ST_DONE : ST_PRIME;
                end
            end
            ST_PRIME, ST_STREAM: begin
                if (w_shift) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_row_nxt >= ROW_K) begin
                        w_state_nxt = ST_STREAM;
                    end else begin
                        w_state_nxt = ST_PRIME;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready_o      = w_ready;
    assign shift_o      = w_shift;
    assign valid_o      = valid_i && w_in_win && w_active;
    assign col_o        = w_col_eff;
    assign row_o        = w_row_eff;
    assign frame_done_o = (r_state == ST_DONE);

`ifdef WINDOW_SEQ_CTRL_STATS_EN
    logic [15:0] r_frame_cnt;
    logic        r_err;

    // Frame counter and sticky resync flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_frame_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == ST_DONE) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            if (w_sync && w_shift) begin
                r_err <= 1'b1;
            end
        end
    end

    assign frame_count_o = r_frame_cnt;
    assign err_o         = r_err;
`endif

endmodule
